pdm_cic_decimator: RTL

Single-clock PDM-to-PCM front end. Synchronises the MEMS microphone `pdm`/`pdm_clk` pins into the system clock domain and runs an ORDER-stage CIC decimator. Emits signed PCM samples on a valid/ready port that feeds the IIR filter and Avalon on-chip writer stage. It replaces the raw 1-bit expansion currently done on `pdm_clk`, so everything downstream of the microphone runs on `clock`.

---
 rtl/pdm_cic_decimator.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: PDM mic synchroniser + ORDER-stage CIC decimator.
// Macro PDM_CIC_ROUND_EN: round half-up with positive saturation.
module pdm_cic_decimator #(
  parameter int ORDER = 4,
  parameter int DECIM = 64,
  parameter int OUT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pdm,
  input  logic             pdm_clk,
  input  logic             enable,
  output logic [OUT_W-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  output logic [31:0]      sample_count
);

  localparam int ACC_W = ORDER * $clog2(DECIM) + 2;
  localparam int CNT_W = $clog2(DECIM);
  localparam int STG_W = (ORDER > 1) ? $clog2(ORDER) : 1;
  localparam int WRM_W = $clog2(ORDER + 1);
  localparam int SH    = ACC_W - OUT_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMB,
    S_OUT
  } state_t;

  logic [1:0]       pdm_sync;
  logic [2:0]       clk_sync;
  logic             strobe;
  logic             bit_in;
  logic [ACC_W-1:0] acc_in;
  logic [ACC_W-1:0] integ [ORDER];
  logic [ACC_W-1:0] dly   [ORDER];
  logic [ACC_W-1:0] work;
  logic [CNT_W-1:0] dec_cnt;
  logic             tick;
  state_t           state;
  logic [STG_W-1:0] stage;
  logic [WRM_W-1:0] warm;
  logic [OUT_W-1:0] pcm;
  logic             xfer;
  logic             warm_done;
  logic             out_live;

  // Two-flop synchronisers, third pdm_clk flop for rising-edge detect
  always_ff @(posedge clock) begin
    if (reset) begin
      pdm_sync <= '0;
      clk_sync <= '0;
    end else begin
      pdm_sync <= {pdm_sync[0], pdm};
      clk_sync <= {clk_sync[1:0], pdm_clk};
    end
  end

  assign strobe = clk_sync[1] & ~clk_sync[2];
  assign bit_in = pdm_sync[1];
  assign acc_in = bit_in ? ACC_W'(1) : '1;
  assign tick   = strobe && (dec_cnt == CNT_W'(DECIM - 1));

  // Integrator cascade, wraps modulo 2^ACC_W by design
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      for (int k = 0; k < ORDER; k++)
        integ[k] <= '0;
    end else if (strobe) begin
      integ[0] <= integ[0] + acc_in;
      for (int k = 1; k < ORDER; k++)
        integ[k] <= integ[k] + integ[k-1];
    end
  end

  // Decimation counter, natural power-of-two wrap
  always_ff @(posedge clock) begin
    if (reset || !enable)
      dec_cnt <= '0;
    else if (strobe)
      dec_cnt <= dec_cnt + CNT_W'(1);
  end

  // Comb FSM: latch, one comb stage per clock, then OUT
  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      state <= S_IDLE;
      stage <= '0;
      work  <= '0;
      for (int k = 0; k < ORDER; k++)
        dly[k] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (tick) begin
            work  <= integ[ORDER-1];
            stage <= '0;
            state <= S_COMB;
          end
        end
        S_COMB: begin
          work       <= work - dly[stage];
          dly[stage] <= work;
          if (stage == STG_W'(ORDER - 1))
            state <= S_OUT;
          else
            stage <= stage + STG_W'(1);
        end
        S_OUT: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PDM_CIC_ROUND_EN
  localparam logic [ACC_W:0] RND = (ACC_W+1)'((2 ** SH) >> 1);

  logic [ACC_W:0] rnd_sum;

  // Round half-up; a positive carry into the sign saturates
  always_comb begin
    rnd_sum = {work[ACC_W-1], work} + RND;
    if (rnd_sum[ACC_W] != rnd_sum[ACC_W-1])
      pcm = {1'b0, {(OUT_W-1){1'b1}}};
    else
      pcm = rnd_sum[ACC_W-1:SH];
  end
`else
  assign pcm = work[ACC_W-1:SH];
`endif

  assign xfer      = sample_valid & sample_ready;
  assign warm_done = (warm == WRM_W'(ORDER));
  assign out_live  = (state == S_OUT) && warm_done;

  // Warm-up discard, output register, handshake, overrun, count
  always_ff @(posedge clock) begin
    if (reset) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      sample_count <= '0;
      warm         <= '0;
    end else if (!enable) begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      warm         <= '0;
    end else begin
      if ((state == S_OUT) && !warm_done)
        warm <= warm + WRM_W'(1);
      if (xfer) begin
        sample_count <= sample_count + 32'd1;
        sample_valid <= 1'b0;
      end
      if (out_live) begin
        if (!sample_valid || xfer) begin
          sample_data  <= pcm;
          sample_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule
